or_mask_splitter: RTL



---
 rtl/or_split_pkg.sv | 13 +
 rtl/lsb_index_enc.sv | 21 ++
 rtl/or_mask_splitter.sv | 94 +++++++++
 3 files changed

// File: rtl/or_split_pkg.sv
// or_split_pkg: shared constants and FSM state encoding for or_mask_splitter.
//   WIDTH   - mask width
//   IDXW    - bit index width, log2(WIDTH)
//   state_t - splitter FSM states (IDLE, SPLIT)
package or_split_pkg;
    localparam int WIDTH = 32;
    localparam int IDXW  = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_t;
endpackage

// File: rtl/lsb_index_enc.sv
// lsb_index_enc: combinational one-hot to binary index encoder.
//   onehot - input word with at most one bit set
//   index  - position of the set bit, 0 for an all-zero input
// The index is the OR of the positions of all set bits. That is exact for a
// one-hot input and yields 0 for an all-zero one.
module lsb_index_enc
    import or_split_pkg::*;
#(
    parameter int W  = WIDTH,
    parameter int IW = IDXW
) (
    input  logic [W-1:0]  onehot,
    output logic [IW-1:0] index
);
    always_comb begin
        index = '0;
        for (int i = 0; i < W; i++) begin
            if (onehot[i]) index = index | IW'(i);
        end
    end
endmodule

// File: rtl/or_mask_splitter.sv
// or_mask_splitter: splits a mask into its set bits, one beat per bit, LSB
// first. Each beat carries a one-hot word and the matching bit index. A zero
// mask produces one beat flagged out_zero.
//   clock, reset_n           - clock, asynchronous active-low reset
//   in_valid/in_ready/in_mask - mask input handshake (accepted only in IDLE)
//   out_valid/out_ready       - beat output handshake
//   out_onehot/out_index      - lowest remaining set bit and its position
//   out_last/out_zero         - final beat of the mask / mask was all zero
//   chk_err                   - sticky reconstruction error
// Optional macro OR_SPLIT_CHECK_EN: when it is defined, the block ORs the
// transferred beats back together and compares the result with the accepted
// mask. When it is not defined, chk_err is tied to 0.
module or_mask_splitter
    import or_split_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_onehot,
    output logic [IDXW-1:0]  out_index,
    output logic             out_last,
    output logic             out_zero,
    output logic             chk_err
);
    state_t           state;
    logic [WIDTH-1:0] rem;
    logic             accept;
    logic             xfer;

    // All outputs come from state and rem. In IDLE, rem is 0, so the beat
    // fields rest at onehot=0, index=0, last=1, zero=1.
    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == SPLIT);
    assign out_onehot = rem & (~rem + WIDTH'(1));
    assign out_last   = (rem & (rem - WIDTH'(1))) == '0;
    assign out_zero   = (rem == '0);

    assign accept = in_valid & in_ready;
    assign xfer   = out_valid & out_ready;

    lsb_index_enc #(.W(WIDTH), .IW(IDXW)) u_enc (
        .onehot (out_onehot),
        .index  (out_index)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            rem   <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    rem   <= in_mask;
                    state <= SPLIT;
                end
                SPLIT: if (xfer) begin
                    rem <= rem & ~out_onehot;
                    if (out_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef OR_SPLIT_CHECK_EN
    logic [WIDTH-1:0] orig;
    logic [WIDTH-1:0] recon;
    logic             err_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            orig  <= '0;
            recon <= '0;
            err_q <= 1'b0;
        end else if (accept) begin
            orig  <= in_mask;
            recon <= '0;
        end else if (xfer) begin
            recon <= recon | out_onehot;
            // The last beat is included in the compare because recon has not
            // yet absorbed it.
            if (out_last && ((recon | out_onehot) != orig)) err_q <= 1'b1;
        end
    end

    assign chk_err = err_q;
`else
    assign chk_err = 1'b0;
`endif
endmodule
